bus_responder: RTL and testbench

BUS_RESPONDER -- requirements
Module: bus_responder

---
 rtl/bus_pkg.sv | 34 +++
 rtl/bus_resp_ram.sv | 24 ++
 rtl/bus_responder.sv | 149 ++++++++++++++
 tb/tb_bus_responder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared encodings for the bus responder: access sizes, FSM states, wait-counter width
// and byte-lane helpers.
package bus_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    localparam int unsigned CNT_W = 4;

    // Lane offset of the access; low bits below the access size are dropped (force-align).
    function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return addr_lo;
            SIZE_HALF: return {addr_lo[1], 1'b0};
            default:   return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 4'b0001;
            SIZE_HALF: return 4'b0011;
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/bus_resp_ram.sv
// Backing store for the bus responder: DEPTH_WORDS x 32, synchronous read, per-byte write enable.
module bus_resp_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        rdata <= mem[addr];
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/bus_responder.sv
// Wait-state bus responder in front of a byte-enabled word RAM.
// Optional macro BUS_RESP_MISALIGN_CHK_EN turns misaligned half/word accesses into errors.
module bus_responder
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  a_reset_l,
    input  logic                  i_bus_en,
    input  logic                  i_bus_wen,
    input  logic [ADDR_WIDTH-1:0] i_bus_addr,
    input  logic [1:0]            i_bus_size,
    input  logic [31:0]           i_store_data,
    output logic                  o_bus_ready,
    output logic [31:0]           o_load_data,
    output logic                  o_bus_err
);

    localparam int unsigned RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  skip_q, skip_d;
    logic                  capture;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic [31:0]           wdata_q;

    logic [IDX_W-1:0]      word_idx;
    logic                  out_of_range;
    logic                  misalign;
    logic                  access_err;
    logic [1:0]            off;
    logic [RAM_AW-1:0]     ram_addr;
    logic [3:0]            ram_be;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;
    logic [31:0]           shifted;
    logic [31:0]           load_val;

    // skip_q blocks acceptance for the one IDLE cycle right after RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        skip_d  = skip_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                skip_d = 1'b0;
                if (i_bus_en && !skip_q) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                skip_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge a_reset_l) begin
        if (!a_reset_l) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            skip_q  <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            size_q  <= SIZE_BYTE;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            skip_q  <= skip_d;
            if (capture) begin
                wen_q   <= i_bus_wen;
                addr_q  <= i_bus_addr;
                size_q  <= i_bus_size;
                wdata_q <= i_store_data;
            end
        end
    end

    assign word_idx     = addr_q[ADDR_WIDTH-1:2];
    assign out_of_range = 32'(word_idx) >= DEPTH_WORDS;

`ifdef BUS_RESP_MISALIGN_CHK_EN
    assign misalign = ((size_q == SIZE_HALF) && addr_q[0]) ||
                      ((size_q == SIZE_WORD) && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign access_err = out_of_range || (size_q == SIZE_RSVD) || misalign;
    assign off        = lane_offset(size_q, addr_q[1:0]);

    // In IDLE the RAM reads the incoming address so zero-wait responses have data in RESP.
    assign ram_addr  = (state_q == ST_IDLE) ? i_bus_addr[RAM_AW+1:2] : addr_q[RAM_AW+1:2];
    assign ram_be    = (state_q == ST_RESP && wen_q && !access_err) ?
                       (lane_mask(size_q) << off) : 4'b0000;
    assign ram_wdata = wdata_q << {off, 3'b000};

    bus_resp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign shifted = ram_rdata >> {off, 3'b000};

    always_comb begin
        load_val = '0;
        case (size_q)
            SIZE_BYTE: load_val = {24'b0, shifted[7:0]};
            SIZE_HALF: load_val = {16'b0, shifted[15:0]};
            SIZE_WORD: load_val = shifted;
            default:   load_val = '0;
        endcase
    end

    assign o_bus_ready = (state_q == ST_RESP);
    assign o_bus_err   = o_bus_ready && access_err;
    assign o_load_data = (o_bus_ready && !access_err) ? load_val : '0;

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: expectations are queued per request and popped on ready.
module tb_bus_responder;

    localparam int TB_WAIT = 2;
    localparam int TB_LAT  = TB_WAIT + 1;

    logic        clk = 1'b0;
    logic        a_reset_l = 1'b0;
    logic        i_bus_en = 1'b0;
    logic        i_bus_wen = 1'b0;
    logic [15:0] i_bus_addr = '0;
    logic [1:0]  i_bus_size = '0;
    logic [31:0] i_store_data = '0;
    logic        o_bus_ready;
    logic [31:0] o_load_data;
    logic        o_bus_err;

    bus_responder #(
        .ADDR_WIDTH  (16),
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (TB_WAIT)
    ) dut (
        .clk          (clk),
        .a_reset_l    (a_reset_l),
        .i_bus_en     (i_bus_en),
        .i_bus_wen    (i_bus_wen),
        .i_bus_addr   (i_bus_addr),
        .i_bus_size   (i_bus_size),
        .i_store_data (i_store_data),
        .o_bus_ready  (o_bus_ready),
        .o_load_data  (o_load_data),
        .o_bus_err    (o_bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wen;
        logic [15:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        chk_data;
    } req_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

`ifdef BUS_RESP_MISALIGN_CHK_EN
    localparam logic [31:0] MEM10_FINAL = 32'hA5AD1234;
`else
    localparam logic [31:0] MEM10_FINAL = 32'h0BADF00D;
`endif

    // Drives one request, waits (bounded) for ready, then leaves two idle cycles.
    task automatic issue(input logic wen, input logic [15:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata, output logic [31:0] data, output logic err,
                         output int lat, output logic leak, output logic timeout);
        lat = 0; leak = 1'b0; timeout = 1'b1; data = '0; err = 1'b0;
        @(negedge clk);
        i_bus_en = 1'b1; i_bus_wen = wen; i_bus_addr = addr; i_bus_size = size;
        i_store_data = wdata;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (o_bus_ready) begin
                lat = i; data = o_load_data; err = o_bus_err; timeout = 1'b0;
                break;
            end
            if (o_load_data !== 32'h0) leak = 1'b1;
        end
        i_bus_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic run_table(input string name, input req_t t[], input int n);
    endtask

    task automatic test_reset();
        a_reset_l = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_bus_ready !== 1'b0 || o_load_data !== 32'h0 || o_bus_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b data=%h err=%b, required 0/00000000/0",
                     o_bus_ready, o_load_data, o_bus_err);
        end
        a_reset_l = 1'b1;
        @(negedge clk);
        checks++;
        if (o_bus_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_ready: ready=%b, required 0", o_bus_ready);
        end
    endtask

    task automatic test_word();
        req_t t[2];
        logic [31:0] d; logic e, lk, to; int l; exp_t x;
        t[0] = '{1'b1, 16'h0010, 2'b10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
        t[1] = '{1'b0, 16'h0010, 2'b10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{t[i].exp_data, t[i].exp_err, t[i].chk_data});
            issue(t[i].wen, t[i].addr, t[i].size, t[i].wdata, d, e, l, lk, to);
            x = sb.pop_front();
            checks++;
            if (to || lk || e !== x.err || (x.chk && d !== x.data) || l != TB_LAT) begin
                errors++;
                $display("FAIL word[%0d]: data=%h err=%b lat=%0d leak=%b timeout=%b, required data=%h err=%b lat=%0d",
                         i, d, e, l, lk, to, x.data, x.err, TB_LAT);
            end
        end
    endtask

    task automatic test_byte();
        req_t t[3];
        logic [31:0] d; logic e, lk, to; int l; exp_t x;
        t[0] = '{1'b1, 16'h0013, 2'b00, 32'h000000A5, 32'h0, 1'b0, 1'b0};
        t[1] = '{1'b0, 16'h0010, 2'b10, 32'h0, 32'hA5ADBEEF, 1'b0, 1'b1};
        t[2] = '{1'b0, 16'h0012, 2'b00, 32'h0, 32'h000000AD, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{t[i].exp_data, t[i].exp_err, t[i].chk_data});
            issue(t[i].wen, t[i].addr, t[i].size, t[i].wdata, d, e, l, lk, to);
            x = sb.pop_front();
            checks++;
            if (to || lk || e !== x.err || (x.chk && d !== x.data) || l != TB_LAT) begin
                errors++;
                $display("FAIL byte[%0d]: data=%h err=%b lat=%0d leak=%b timeout=%b, required data=%h err=%b lat=%0d",
                         i, d, e, l, lk, to, x.data, x.err, TB_LAT);
            end
        end
    endtask

    task automatic test_half();
        req_t t[3];
        logic [31:0] d; logic e, lk, to; int l; exp_t x;
        t[0] = '{1'b0, 16'h0012, 2'b01, 32'h0, 32'h0000A5AD, 1'b0, 1'b1};
        t[1] = '{1'b1, 16'h0010, 2'b01, 32'h00001234, 32'h0, 1'b0, 1'b0};
        t[2] = '{1'b0, 16'h0010, 2'b10, 32'h0, 32'hA5AD1234, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{t[i].exp_data, t[i].exp_err, t[i].chk_data});
            issue(t[i].wen, t[i].addr, t[i].size, t[i].wdata, d, e, l, lk, to);
            x = sb.pop_front();
            checks++;
            if (to || lk || e !== x.err || (x.chk && d !== x.data) || l != TB_LAT) begin
                errors++;
                $display("FAIL half[%0d]: data=%h err=%b lat=%0d leak=%b timeout=%b, required data=%h err=%b lat=%0d",
                         i, d, e, l, lk, to, x.data, x.err, TB_LAT);
            end
        end
    endtask

    // Index 1024 aliases word 0 in the RAM, so a leaked write would show up at 0x0000.
    task automatic test_out_of_range();
        req_t t[7];
        logic [31:0] d; logic e, lk, to; int l; exp_t x;
        t[0] = '{1'b1, 16'h0000, 2'b10, 32'h55667788, 32'h0, 1'b0, 1'b0};
        t[1] = '{1'b0, 16'h1000, 2'b10, 32'h0, 32'h0, 1'b1, 1'b1};
        t[2] = '{1'b1, 16'h1000, 2'b10, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0};
        t[3] = '{1'b0, 16'h0000, 2'b10, 32'h0, 32'h55667788, 1'b0, 1'b1};
        t[4] = '{1'b0, 16'h0010, 2'b11, 32'h0, 32'h0, 1'b1, 1'b1};
        t[5] = '{1'b1, 16'h0010, 2'b11, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0};
        t[6] = '{1'b0, 16'h0010, 2'b10, 32'h0, 32'hA5AD1234, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            sb.push_back('{t[i].exp_data, t[i].exp_err, t[i].chk_data});
            issue(t[i].wen, t[i].addr, t[i].size, t[i].wdata, d, e, l, lk, to);
            x = sb.pop_front();
            checks++;
            if (to || lk || e !== x.err || (x.chk && d !== x.data) || l != TB_LAT) begin
                errors++;
                $display("FAIL oob[%0d]: data=%h err=%b lat=%0d leak=%b timeout=%b, required data=%h err=%b lat=%0d",
                         i, d, e, l, lk, to, x.data, x.err, TB_LAT);
            end
        end
    endtask

    task automatic test_misalign();
        req_t t[3];
        logic [31:0] d; logic e, lk, to; int l; exp_t x;
`ifdef BUS_RESP_MISALIGN_CHK_EN
        t[0] = '{1'b0, 16'h0011, 2'b01, 32'h0, 32'h0, 1'b1, 1'b1};
        t[1] = '{1'b1, 16'h0013, 2'b10, 32'h0BADF00D, 32'h0, 1'b1, 1'b0};
`else
        t[0] = '{1'b0, 16'h0011, 2'b01, 32'h0, 32'h00001234, 1'b0, 1'b1};
        t[1] = '{1'b1, 16'h0013, 2'b10, 32'h0BADF00D, 32'h0, 1'b0, 1'b0};
`endif
        t[2] = '{1'b0, 16'h0010, 2'b10, 32'h0, MEM10_FINAL, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{t[i].exp_data, t[i].exp_err, t[i].chk_data});
            issue(t[i].wen, t[i].addr, t[i].size, t[i].wdata, d, e, l, lk, to);
            x = sb.pop_front();
            checks++;
            if (to || lk || e !== x.err || (x.chk && d !== x.data) || l != TB_LAT) begin
                errors++;
                $display("FAIL misalign[%0d]: data=%h err=%b lat=%0d leak=%b timeout=%b, required data=%h err=%b lat=%0d",
                         i, d, e, l, lk, to, x.data, x.err, TB_LAT);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d; logic e, lk, to; int l; exp_t x; int readies;
        sb.push_back('{32'h0, 1'b0, 1'b0});
        issue(1'b1, 16'h0020, 2'b10, 32'h11223344, d, e, l, lk, to);
        x = sb.pop_front();
        checks++;
        if (to || e !== x.err || l != TB_LAT) begin
            errors++;
            $display("FAIL abort_setup: err=%b lat=%0d timeout=%b, required err=%b lat=%0d",
                     e, l, to, x.err, TB_LAT);
        end
        @(negedge clk);
        i_bus_en = 1'b1; i_bus_wen = 1'b1; i_bus_addr = 16'h0020; i_bus_size = 2'b10;
        i_store_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        i_bus_en = 1'b0;
        @(negedge clk);
        a_reset_l = 1'b0;
        #1;
        checks++;
        if (o_bus_ready !== 1'b0 || o_load_data !== 32'h0 || o_bus_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset_outputs: ready=%b data=%h err=%b, required 0/00000000/0",
                     o_bus_ready, o_load_data, o_bus_err);
        end
        @(negedge clk);
        a_reset_l = 1'b1;
        readies = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (o_bus_ready) readies++;
        end
        checks++;
        if (readies != 0) begin
            errors++;
            $display("FAIL abort_no_ready: ready pulses=%0d, required 0", readies);
        end
        sb.push_back('{32'h11223344, 1'b0, 1'b1});
        issue(1'b0, 16'h0020, 2'b10, 32'h0, d, e, l, lk, to);
        x = sb.pop_front();
        checks++;
        if (to || lk || e !== x.err || d !== x.data || l != TB_LAT) begin
            errors++;
            $display("FAIL abort_reload: data=%h err=%b lat=%0d timeout=%b, required data=%h err=%b lat=%0d",
                     d, e, l, to, x.data, x.err, TB_LAT);
        end
    endtask

    task automatic test_back_to_back();
        int readies; int lat; logic [31:0] d; exp_t x;
        readies = 0; lat = 0; d = '0;
        sb.push_back('{MEM10_FINAL, 1'b0, 1'b1});
        @(negedge clk);
        i_bus_en = 1'b1; i_bus_wen = 1'b0; i_bus_addr = 16'h0010; i_bus_size = 2'b10;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (o_bus_ready) begin
                readies++; lat = i; d = o_load_data;
                break;
            end
        end
        // Hold the request through RESP and the following cycle.
        repeat (2) begin
            @(posedge clk); #1;
            if (o_bus_ready) readies++;
        end
        i_bus_en = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (o_bus_ready) readies++;
        end
        x = sb.pop_front();
        checks++;
        if (readies != 1 || lat != TB_LAT || d !== x.data) begin
            errors++;
            $display("FAIL held_en: ready pulses=%0d lat=%0d data=%h, required 1 pulse lat=%0d data=%h",
                     readies, lat, d, TB_LAT, x.data);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_out_of_range();
        test_misalign();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
